// File: rtl/hazard_pkg.sv
// hazard_pkg: opcode classes, controller state enum and sizing helpers for pipe_hazard_stall_ctrl.
package hazard_pkg;

    localparam int OPC_W = 16;
    typedef logic [OPC_W-1:0] opc_t;

    localparam opc_t OP_ATYPE = 16'h0001;
    localparam opc_t OP_LW    = 16'h0006;
    localparam opc_t OP_LH    = 16'h0004;
    localparam opc_t OP_BEQ   = 16'h000c;
    localparam opc_t OP_BNE   = 16'h000d;
    localparam opc_t OP_BLT   = 16'h000e;

    typedef enum logic [1:0] {S_RUN, S_STALL, S_FLUSH} state_t;

    function automatic logic is_load(input opc_t op);
        return op == OP_LW || op == OP_LH;
    endfunction

    function automatic logic is_atype(input opc_t op);
        return op == OP_ATYPE;
    endfunction

    function automatic logic is_branch(input opc_t op);
        return op == OP_BEQ || op == OP_BNE || op == OP_BLT;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        return (a > b ? a : b) > c ? (a > b ? a : b) : c;
    endfunction

    function automatic int need_w(input int m);
        return m < 2 ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/hazard_need_calc.sv
// hazard_need_calc: combinational stall-count evaluation for the instruction in ID.
module hazard_need_calc
    import hazard_pkg::*;
#(
    parameter int OP_W            = 4,
    parameter int REG_AW          = 5,
    parameter int LOAD_USE_STALLS = 1,
    parameter int BR_ALU_STALLS   = 1,
    parameter int BR_LOAD_STALLS  = 2,
    parameter int NW              = 2
)(
    input  logic [OP_W-1:0]   id_op,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [OP_W-1:0]   ex_op,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic [OP_W-1:0]   mem_op,
    input  logic [REG_AW-1:0] mem_rd,
    output logic [NW-1:0]     need
);
    logic br, ex_m, mem_m, ex_ld, ex_a, mem_ld;
    always_comb begin
        br     = is_branch(OPC_W'(id_op));
        ex_ld  = is_load(OPC_W'(ex_op));
        ex_a   = is_atype(OPC_W'(ex_op));
        mem_ld = is_load(OPC_W'(mem_op));
        // register 0 is hardwired, so it never carries a dependency
        ex_m   = ex_rd != '0 && (ex_rd == id_rs || ex_rd == id_rt);
        mem_m  = mem_rd != '0 && (mem_rd == id_rs || mem_rd == id_rt);
        need   = (br && ex_ld && ex_m)   ? NW'(BR_LOAD_STALLS) :
                 (br && ex_a && ex_m)    ? NW'(BR_ALU_STALLS) :
                 (br && mem_ld && mem_m) ? NW'(BR_LOAD_STALLS - 1) :
                 (!br && ex_ld && ex_m)  ? NW'(LOAD_USE_STALLS) : '0;
    end
endmodule

// File: rtl/pipe_hazard_stall_ctrl.sv
// pipe_hazard_stall_ctrl: stall/flush FSM driving PC, IF/ID and ID/EX controls.
// Optional perf counters when HAZ_PERF_CNT_EN is defined.
module pipe_hazard_stall_ctrl
    import hazard_pkg::*;
#(
    parameter int OP_W            = 4,
    parameter int REG_AW          = 5,
    parameter int LOAD_USE_STALLS = 1,
    parameter int BR_ALU_STALLS   = 1,
    parameter int BR_LOAD_STALLS  = 2
`ifdef HAZ_PERF_CNT_EN
    ,
    parameter int CNT_W           = 32
`endif
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [OP_W-1:0]   id_op,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [OP_W-1:0]   ex_op,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic [OP_W-1:0]   mem_op,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              branch_taken,
    input  logic              ext_freeze,
    output logic              pc_hold,
    output logic              ifid_hold,
    output logic              idex_bubble,
    output logic              ifid_flush,
    output logic              stall_busy
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]  perf_stall_cyc,
    output logic [CNT_W-1:0]  perf_flush_cnt
`endif
);
    localparam int NW = need_w(max3(LOAD_USE_STALLS, BR_ALU_STALLS, BR_LOAD_STALLS));

    logic [NW-1:0] need, cnt, cnt_nxt;
    state_t        state, state_nxt;
    logic          hold, bubble, flush;

    hazard_need_calc #(
        .OP_W(OP_W), .REG_AW(REG_AW), .LOAD_USE_STALLS(LOAD_USE_STALLS),
        .BR_ALU_STALLS(BR_ALU_STALLS), .BR_LOAD_STALLS(BR_LOAD_STALLS), .NW(NW)
    ) u_need (
        .id_op(id_op), .id_rs(id_rs), .id_rt(id_rt), .ex_op(ex_op), .ex_rd(ex_rd),
        .mem_op(mem_op), .mem_rd(mem_rd), .need(need)
    );

    // a pending stall always wins over a taken branch: operands are not ready yet
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        hold      = 1'b0;
        bubble    = 1'b0;
        flush     = 1'b0;
        if (ext_freeze) begin
            hold = 1'b1;
        end else if (state == S_STALL) begin
            hold      = 1'b1;
            bubble    = 1'b1;
            cnt_nxt   = cnt - NW'(1);
            state_nxt = (cnt == NW'(1)) ? S_RUN : S_STALL;
        end else if (state == S_FLUSH) begin
            state_nxt = S_RUN;
        end else if (need != '0) begin
            hold      = 1'b1;
            bubble    = 1'b1;
            cnt_nxt   = (need == NW'(1)) ? cnt : need - NW'(1);
            state_nxt = (need == NW'(1)) ? S_RUN : S_STALL;
        end else if (branch_taken) begin
            flush     = 1'b1;
            state_nxt = S_FLUSH;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_RUN;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    assign pc_hold     = rst_n & hold;
    assign ifid_hold   = rst_n & hold;
    assign idex_bubble = rst_n & bubble;
    assign ifid_flush  = rst_n & flush;
    assign stall_busy  = rst_n & (state == S_STALL);

`ifdef HAZ_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_cyc <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (idex_bubble && perf_stall_cyc != '1) perf_stall_cyc <= perf_stall_cyc + 1'b1;
            if (ifid_flush && perf_flush_cnt != '1) perf_flush_cnt <= perf_flush_cnt + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_pipe_hazard_stall_ctrl.sv
// tb_pipe_hazard_stall_ctrl: directed and random checks against a remaining-cycles reference model.
module tb_pipe_hazard_stall_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] id_op = '0, ex_op = '0, mem_op = '0;
    logic [4:0] id_rs = '0, id_rt = '0, ex_rd = '0, mem_rd = '0;
    logic       branch_taken = 1'b0, ext_freeze = 1'b0;
    logic       pc_hold, ifid_hold, idex_bubble, ifid_flush, stall_busy;
    int         tests = 0, fails = 0;
    int         rem = 0;
    bit         fl = 1'b0;
    int         tot_hold = 0, tot_bub = 0, tot_flush = 0, tot_busy = 0;
    int         ps = 0, pf = 0;

    always #5 clk = ~clk;

`ifdef HAZ_PERF_CNT_EN
    localparam int PMAX = 15;
    logic [3:0] perf_stall_cyc, perf_flush_cnt;
    pipe_hazard_stall_ctrl #(.CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .id_op(id_op), .id_rs(id_rs), .id_rt(id_rt),
        .ex_op(ex_op), .ex_rd(ex_rd), .mem_op(mem_op), .mem_rd(mem_rd),
        .branch_taken(branch_taken), .ext_freeze(ext_freeze),
        .pc_hold(pc_hold), .ifid_hold(ifid_hold), .idex_bubble(idex_bubble),
        .ifid_flush(ifid_flush), .stall_busy(stall_busy),
        .perf_stall_cyc(perf_stall_cyc), .perf_flush_cnt(perf_flush_cnt));
`else
    pipe_hazard_stall_ctrl dut (
        .clk(clk), .rst_n(rst_n), .id_op(id_op), .id_rs(id_rs), .id_rt(id_rt),
        .ex_op(ex_op), .ex_rd(ex_rd), .mem_op(mem_op), .mem_rd(mem_rd),
        .branch_taken(branch_taken), .ext_freeze(ext_freeze),
        .pc_hold(pc_hold), .ifid_hold(ifid_hold), .idex_bubble(idex_bubble),
        .ifid_flush(ifid_flush), .stall_busy(stall_busy));
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // stall cycles the ID instruction needs, straight from the hazard table
    function automatic int model_need();
        bit br, mex, mmem;
        br   = id_op inside {4'hc, 4'hd, 4'he};
        mex  = ex_rd != 0 && (ex_rd == id_rs || ex_rd == id_rt);
        mmem = mem_rd != 0 && (mem_rd == id_rs || mem_rd == id_rt);
        if (br && ex_op inside {4'h6, 4'h4} && mex) return 2;
        if (br && ex_op == 4'h1 && mex) return 1;
        if (br && mem_op inside {4'h6, 4'h4} && mmem) return 1;
        if (!br && ex_op inside {4'h6, 4'h4} && mex) return 1;
        return 0;
    endfunction

    task automatic set(input logic [3:0] iop, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [3:0] eop, input logic [4:0] erd, input logic [3:0] mop,
                       input logic [4:0] mrd, input logic bt, input logic fz);
        id_op = iop; id_rs = rs; id_rt = rt; ex_op = eop; ex_rd = erd;
        mem_op = mop; mem_rd = mrd; branch_taken = bt; ext_freeze = fz;
    endtask

    task automatic step();
        int  need;
        bit  eb, eh, ef, es;
        #1;
        need = model_need();
        eb = !ext_freeze && (rem > 0 || (!fl && need > 0));
        eh = ext_freeze || eb;
        ef = !ext_freeze && rem == 0 && !fl && need == 0 && branch_taken;
        es = rem > 0;
        chk("pc_hold", pc_hold, eh);
        chk("ifid_hold", ifid_hold, eh);
        chk("idex_bubble", idex_bubble, eb);
        chk("ifid_flush", ifid_flush, ef);
        chk("stall_busy", stall_busy, es);
`ifdef HAZ_PERF_CNT_EN
        chk("perf_stall_cyc", perf_stall_cyc, ps);
        chk("perf_flush_cnt", perf_flush_cnt, pf);
`endif
        tot_hold += int'(pc_hold); tot_bub += int'(idex_bubble);
        tot_flush += int'(ifid_flush); tot_busy += int'(stall_busy);
        @(posedge clk);
        if (eb && ps < 15) ps++;
        if (ef && pf < 15) pf++;
        if (!ext_freeze) begin
            if (rem > 0) rem--;
            else if (fl) fl = 1'b0;
            else if (need > 0) rem = need - 1;
            else if (branch_taken) fl = 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic clr_tot();
        tot_hold = 0; tot_bub = 0; tot_flush = 0; tot_busy = 0;
    endtask

    // asynchronous reset asserted mid-cycle while the inputs present a hazard
    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_pc_hold", pc_hold, 0);
        chk("rst_ifid_hold", ifid_hold, 0);
        chk("rst_idex_bubble", idex_bubble, 0);
        chk("rst_ifid_flush", ifid_flush, 0);
        chk("rst_stall_busy", stall_busy, 0);
        rem = 0; fl = 1'b0; ps = 0; pf = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        set(4'h1, 5'd3, 5'd0, 4'h6, 5'd3, 4'h0, 5'd0, 1'b1, 1'b0);
        @(negedge clk);
        do_reset();

        // load-use: single cycle of hold+bubble, never busy
        clr_tot();
        set(4'h1, 5'd3, 5'd0, 4'h6, 5'd3, 4'h0, 5'd0, 1'b0, 1'b0); step();
        set(4'h0, 5'd0, 5'd0, 4'h0, 5'd0, 4'h0, 5'd0, 1'b0, 1'b0); step();
        chk("t1_hold_total", tot_hold, 1);
        chk("t1_busy_total", tot_busy, 0);

        // branch after load: two cycles, busy in the second
        clr_tot();
        set(4'hc, 5'd0, 5'd7, 4'h4, 5'd7, 4'h0, 5'd0, 1'b0, 1'b0); step(); step();
        set(4'h0, 5'd0, 5'd0, 4'h0, 5'd0, 4'h0, 5'd0, 1'b0, 1'b0); step();
        chk("t2_bubble_total", tot_bub, 2);
        chk("t2_busy_total", tot_busy, 1);

        // register 0 never stalls
        clr_tot();
        set(4'h1, 5'd0, 5'd0, 4'h6, 5'd0, 4'h6, 5'd0, 1'b0, 1'b0); step();
        chk("t3_hold_total", tot_hold, 0);

        // flush one cycle, second branch during S_FLUSH ignored; flush deferred behind stall
        clr_tot();
        set(4'hd, 5'd1, 5'd2, 4'h0, 5'd0, 4'h0, 5'd0, 1'b1, 1'b0); step(); step();
        set(4'h0, 5'd0, 5'd0, 4'h0, 5'd0, 4'h0, 5'd0, 1'b0, 1'b0); step();
        chk("t4_flush_total", tot_flush, 1);
        clr_tot();
        set(4'hc, 5'd0, 5'd7, 4'h4, 5'd7, 4'h0, 5'd0, 1'b1, 1'b0); step(); step();
        chk("t4_no_flush_in_stall", tot_flush, 0);
        set(4'hc, 5'd0, 5'd7, 4'h0, 5'd0, 4'h0, 5'd0, 1'b1, 1'b0); step();
        chk("t4_flush_after_stall", tot_flush, 1);
        set(4'h0, 5'd0, 5'd0, 4'h0, 5'd0, 4'h0, 5'd0, 1'b0, 1'b0); step();

        // freeze for 3 cycles inside the 2-cycle stall
        clr_tot();
        set(4'hc, 5'd0, 5'd7, 4'h4, 5'd7, 4'h0, 5'd0, 1'b0, 1'b0); step();
        ext_freeze = 1'b1; step(); step(); step();
        ext_freeze = 1'b0; step();
        set(4'h0, 5'd0, 5'd0, 4'h0, 5'd0, 4'h0, 5'd0, 1'b0, 1'b0); step();
        chk("t5_hold_total", tot_hold, 5);
        chk("t5_bubble_total", tot_bub, 2);

        // reset in the middle of a stall
        set(4'hc, 5'd0, 5'd7, 4'h4, 5'd7, 4'h0, 5'd0, 1'b0, 1'b0); step();
        chk("t6_busy_before_rst", stall_busy, 1);
        do_reset();
        set(4'h0, 5'd0, 5'd0, 4'h0, 5'd0, 4'h0, 5'd0, 1'b0, 1'b0); step();

        // random traffic, small register pool for frequent matches
        for (int i = 0; i < 600; i++) begin
            logic [3:0] ops [8];
            ops = '{4'h1, 4'h6, 4'h4, 4'hc, 4'hd, 4'he, 4'h0, 4'h2};
            set(ops[$urandom_range(7)], 5'($urandom_range(3)), 5'($urandom_range(3)),
                ops[$urandom_range(7)], 5'($urandom_range(3)),
                ops[$urandom_range(7)], 5'($urandom_range(3)),
                1'($urandom_range(1)), $urandom_range(7) == 0);
            if ($urandom_range(79) == 0) do_reset();
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end
endmodule
